// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller.
// Holds digit width, enable polarity, scan state encoding and a clog2 helper.
// Imported by scan_timer and display_scan_ctrl.
package display_pkg;

    localparam int   DIGIT_W = 4;
    localparam logic DIG_ON  = 1'b0;   // common-anode digits: low lights the digit

    typedef enum logic {
        GUARD = 1'b0,
        ON    = 1'b1
    } scan_state_t;

    // Ceiling log2, never below 1 so it is always usable as a vector width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot counter and digit index for the scan controller.
// Ports: clk/reset in; cnt (position inside the slot), slot_end/frame_end strobes
// for the current cycle, idx_next (digit index valid after the coming edge).
module scan_timer
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SLOT_CYCLES = 50000
) (
    input  logic                           clk,
    input  logic                           reset,
    output logic [clog2(SLOT_CYCLES)-1:0]  cnt,
    output logic                           slot_end,
    output logic                           frame_end,
    output logic [clog2(NUM_DIGITS)-1:0]   idx_next
);

    localparam int CNT_W = clog2(SLOT_CYCLES);
    localparam int IDX_W = clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [IDX_W-1:0] idx;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    always_comb begin
        idx_next = idx;
        if (slot_end) begin
            idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            idx <= idx_next;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller driving one shared BCD decoder and active-low digit enables.
// Ports: clk, reset (sync, active-high); load/value_in/blank_mask stage new data, ack pulses on commit;
// number feeds the decoder, digit_en selects the lit digit. Data commits only at the frame boundary.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]         blank_mask,
    output logic                          ack,
    output logic [DIGIT_W-1:0]            number,
    output logic [NUM_DIGITS-1:0]         digit_en
);

    localparam int CNT_W = clog2(SLOT_CYCLES);
    localparam int IDX_W = clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam scan_state_t SLOT_START = (GUARD_CYCLES > 0) ? GUARD : ON;

    logic [CNT_W-1:0] cnt;
    logic             slot_end;
    logic             frame_end;
    logic [IDX_W-1:0] idx_next;

    scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .SLOT_CYCLES (SLOT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .cnt       (cnt),
        .slot_end  (slot_end),
        .frame_end (frame_end),
        .idx_next  (idx_next)
    );

    scan_state_t                   state;
    scan_state_t                   state_next;
    logic [DIGIT_W*NUM_DIGITS-1:0] shadow_val, shadow_val_next, stage_val;
    logic [NUM_DIGITS-1:0]         shadow_mask, shadow_mask_next, stage_mask;
    logic                          pending;
    logic [NUM_DIGITS-1:0]         digit_en_next;

    always_comb begin
        state_next = state;
        if (slot_end) begin
            state_next = SLOT_START;
        end else if (state == GUARD && cnt == GUARD_LAST) begin
            state_next = ON;
        end
    end

    // Shadow only moves at the frame boundary; a load on that very cycle wins
    // over older staged data so it is shown without an extra frame of delay.
    always_comb begin
        shadow_val_next  = shadow_val;
        shadow_mask_next = shadow_mask;
        if (frame_end) begin
            if (load) begin
                shadow_val_next  = value_in;
                shadow_mask_next = blank_mask;
            end else if (pending) begin
                shadow_val_next  = stage_val;
                shadow_mask_next = stage_mask;
            end
        end
    end

    // Outputs are registered from next-cycle state so they line up with the timer.
    always_comb begin
        digit_en_next = '1;
        if (state_next == ON && !shadow_mask_next[idx_next]) begin
            digit_en_next[idx_next] = DIG_ON;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SLOT_START;
            shadow_val  <= '0;
            shadow_mask <= '1;
            stage_val   <= '0;
            stage_mask  <= '0;
            pending     <= 1'b0;
            ack         <= 1'b0;
            number      <= '0;
            digit_en    <= '1;
        end else begin
            state       <= state_next;
            shadow_val  <= shadow_val_next;
            shadow_mask <= shadow_mask_next;
            if (load) begin
                stage_val  <= value_in;
                stage_mask <= blank_mask;
            end
            pending  <= frame_end ? 1'b0 : (pending | load);
            ack      <= frame_end && (pending || load);
            number   <= shadow_val_next[DIGIT_W*idx_next +: DIGIT_W];
            digit_en <= digit_en_next;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

    localparam int N  = 4;
    localparam int S  = 8;
    localparam int G  = 2;
    localparam int FR = N * S;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load = 1'b0;
    logic [15:0]   value_in = '0;
    logic [3:0]    blank_mask = '0;
    logic          ack;
    logic [3:0]    number;
    logic [3:0]    digit_en;

    display_scan_ctrl #(
        .NUM_DIGITS   (N),
        .SLOT_CYCLES  (S),
        .GUARD_CYCLES (G)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .value_in   (value_in),
        .blank_mask (blank_mask),
        .ack        (ack),
        .number     (number),
        .digit_en   (digit_en)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] num;
        logic [3:0] en;
        logic       ack;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: cycle number since reset plus shadow/staging contents.
    int          m_t = 0;
    logic [15:0] m_val, m_stg_val;
    logic [3:0]  m_mask, m_stg_mask;
    bit          m_pend = 0, m_ack = 0, m_live = 0;

    int d_acks = 0;
    int d_last_ack_t = -1;

    function automatic exp_t model_out();
        exp_t e;
        int slot, pos;
        slot = (m_t / S) % N;
        pos  = m_t % S;
        e.num = m_val[4*slot +: 4];
        e.en  = 4'hF;
        if (pos >= G && !m_mask[slot]) e.en = ~(4'b0001 << slot);
        e.ack = m_ack;
        return e;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_t = 0; m_val = '0; m_mask = 4'hF; m_stg_val = '0; m_stg_mask = '0;
            m_pend = 0; m_ack = 0; m_live = 1;
        end else if (m_live) begin
            if ((m_t % FR) == FR - 1) begin
                m_ack = m_pend || load;
                if (load) begin
                    m_val = value_in; m_mask = blank_mask;
                end else if (m_pend) begin
                    m_val = m_stg_val; m_mask = m_stg_mask;
                end
                m_pend = 0;
            end else begin
                m_ack = 0;
                if (load) begin
                    m_stg_val = value_in; m_stg_mask = blank_mask; m_pend = 1;
                end
            end
            m_t++;
        end
        if (m_live) q.push_back(model_out());
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (model cycle %0d)", nm, act, exp_v, m_t);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare against the queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("number", int'(number), int'(e.num));
            chk("digit_en", int'(digit_en), int'(e.en));
            chk("ack", int'(ack), int'(e.ack));
            chk("digit_en_onehot", ($countones(~digit_en) <= 1) ? 1 : 0, 1);
            if (ack === 1'b1) begin
                d_acks++;
                d_last_ack_t = m_t;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pos(input int p);
        int k;
        for (k = 0; k < 2 * FR; k++) begin
            if ((m_t % FR) == p) break;
            @(negedge clk);
        end
        chk("wait_pos_timeout", (k < 2 * FR) ? 1 : 0, 1);
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] m);
        load = 1'b1; value_in = v; blank_mask = m;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic ack_count(input string nm, input int since, input int exp_n);
        @(posedge clk); #1;
        chk(nm, d_acks - since, exp_n);
    endtask

    initial begin
        int a0, lt;
        @(negedge clk); reset = 1'b1;
        idle(2);
        reset = 1'b0;

        // 1: no load, display stays dark
        a0 = d_acks;
        idle(64);
        ack_count("t1_no_ack", a0, 0);

        // 2: load at frame cycle 3, commit at the next boundary
        @(negedge clk);
        wait_pos(3);
        a0 = d_acks; lt = m_t;
        pulse_load(16'h4321, 4'h0);
        idle(FR + 4);
        ack_count("t2_one_ack", a0, 1);
        chk("t2_ack_latency", d_last_ack_t - lt, FR - 3);
        idle(FR);

        // 3: two loads in one frame, newest wins with a single ack
        wait_pos(5);
        a0 = d_acks;
        pulse_load(16'h1111, 4'h0);
        idle(4);
        pulse_load(16'h9999, 4'h0);
        idle(2 * FR);
        ack_count("t3_single_ack", a0, 1);

        // 4: load on the boundary cycle bypasses straight into the shadow
        wait_pos(FR - 1);
        a0 = d_acks; lt = m_t;
        pulse_load(16'h8765, 4'h0);
        idle(2);
        ack_count("t4_one_ack", a0, 1);
        chk("t4_ack_next_cycle", d_last_ack_t - lt, 1);
        idle(FR);

        // 5: blank digit 2
        wait_pos(10);
        pulse_load(16'hCBA5, 4'b0100);
        idle(3 * FR);

        // 6: reset mid-ON of slot 2 with a load pending
        wait_pos(1);
        a0 = d_acks;
        pulse_load(16'h2468, 4'h0);
        wait_pos(2 * S + G + 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle(2 * FR);
        ack_count("t6_no_ack", a0, 0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            load       = ($urandom_range(0, 9) == 0);
            value_in   = 16'($urandom);
            blank_mask = 4'($urandom);
            reset      = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        load = 1'b0; reset = 1'b0;
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
